// File: rtl/hack_alu_pipe_if.sv
// ============================================================================
// Module      : hack_alu_pipe_if
// Description : Input-beat and result handshake bundle for hack_alu_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hack_alu_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [5:0]       ctrl;
   logic             mul;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zr;
   logic             ng;

   modport master (
      output in_valid, x, y, ctrl, mul, out_ready,
      input  in_ready, out_valid, out, zr, ng
   );

   modport slave (
      input  in_valid, x, y, ctrl, mul, out_ready,
      output in_ready, out_valid, out, zr, ng
   );
endinterface

`default_nettype wire

// File: rtl/hack_alu_pipe.sv
// ============================================================================
// Module      : hack_alu_pipe
// Description : Registered Hack ALU with valid/ready in and out. Defining
//               ALU_MUL_EN adds an iterative shift-add multiply (mul=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic            clk,
   input  logic            reset,
   hack_alu_pipe_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
      S_MUL  = 2'd2,
`endif
      S_DONE = 2'd1
   } state_t;

   state_t           r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out;
   logic             r_zr;
   logic             r_ng;

   logic             w_in_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_x1, w_x2, w_y1, w_y2, w_o, w_alu;

`ifdef ALU_MUL_EN
   localparam int                 c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mx;
   logic [WIDTH-1:0]   r_my;
   logic [WIDTH-1:0]   w_acc_next;

   assign w_acc_next = r_acc + (r_my[0] ? r_mx : '0);
`endif

   // DONE passes in_ready straight from out_ready so a draining result makes room
   assign w_in_ready = !reset &&
                       ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
   assign w_accept   = bus.in_valid && w_in_ready;

   assign w_x1  = bus.ctrl[5] ? '0 : bus.x;
   assign w_x2  = bus.ctrl[4] ? ~w_x1 : w_x1;
   assign w_y1  = bus.ctrl[3] ? '0 : bus.y;
   assign w_y2  = bus.ctrl[2] ? ~w_y1 : w_y1;
   assign w_o   = bus.ctrl[1] ? (w_x2 + w_y2) : (w_x2 & w_y2);
   assign w_alu = bus.ctrl[0] ? ~w_o : w_o;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_zr        <= 1'b1;
         r_ng        <= 1'b0;
`ifdef ALU_MUL_EN
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mx        <= '0;
         r_my        <= '0;
`endif
      end else begin
         if ((r_state == S_DONE) && bus.out_ready && !w_accept) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
         end

         if (w_accept) begin
`ifdef ALU_MUL_EN
            if (bus.mul) begin
               r_state     <= S_MUL;
               r_out_valid <= 1'b0;
               r_mx        <= bus.x;
               r_my        <= bus.y;
               r_acc       <= '0;
               r_cnt       <= '0;
            end else
`endif
            begin
               r_state     <= S_DONE;
               r_out_valid <= 1'b1;
               r_out       <= w_alu;
               r_zr        <= (w_alu == '0);
               r_ng        <= w_alu[WIDTH-1];
            end
         end

`ifdef ALU_MUL_EN
         // Only the low half is kept, so signed and unsigned operands agree
         if (r_state == S_MUL) begin
            r_acc <= w_acc_next;
            r_mx  <= r_mx << 1;
            r_my  <= r_my >> 1;
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_last) begin
               r_state     <= S_DONE;
               r_out_valid <= 1'b1;
               r_out       <= w_acc_next;
               r_zr        <= (w_acc_next == '0);
               r_ng        <= w_acc_next[WIDTH-1];
               r_cnt       <= '0;
            end
         end
`endif
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.zr        = r_zr;
   assign bus.ng        = r_ng;

endmodule

`default_nettype wire

// File: doc/hack_alu_pipe.md
# hack_alu_pipe

Parametrised, registered successor to the combinational Hack ALU. It accepts operand/control beats over a valid/ready handshake and returns a registered result with `zr`/`ng` flags through a second valid/ready handshake. It optionally adds an iterative shift-add multiply mode. It sits between the CPU decode stage and the D/A/M writeback path, so a stalled writeback holds the ALU instead of losing results.

## Interface
Parameters:
- `WIDTH`, default 16: data width in bits, minimum 2.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block can accept a beat.
- `x` in `WIDTH`: operand x, two's complement.
- `y` in `WIDTH`: operand y.
- `ctrl` in 6: `{zx,nx,zy,ny,f,no}`, bit 5 = `zx`.
- `mul` in 1: request multiply. Honoured only with `ALU_MUL_EN`.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts result.
- `out` out `WIDTH`: registered result.
- `zr` out 1: registered, `out == 0`.
- `ng` out 1: registered, `out[WIDTH-1]`.

## Operation
- The block accepts a beat on a rising edge where `in_valid & in_ready` is high.
- The result is transferred on a rising edge where `out_valid & out_ready` is high.
- ALU function, all arithmetic mod 2^`WIDTH`:
  - x1 = `zx` ? 0 : `x`; x2 = `nx` ? ~x1 : x1.
  - y1 and y2 are formed from `y` the same way, using `zy` and `ny`.
  - o = `f` ? x2+y2 : x2&y2; result = `no` ? ~o : o.
  - The carry out of the add is discarded.
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
    - Accept with `mul`=0 → DONE. `out`/`zr`/`ng` are registered on the accept edge.
    - Accept with `mul`=1 (macro on) → MUL. Operands are loaded and the accumulator and counter are cleared.
  - MUL: `in_ready`=0, `out_valid`=0.
    - One shift-add iteration per cycle over y's bits, LSB first.
    - The counter runs 0..`WIDTH`-1.
    - On the iteration with counter = `WIDTH`-1, the low `WIDTH` bits of the product and their flags are registered → DONE.
    - `ctrl` is ignored for multiply.
    - Low-half product bits are identical for signed and unsigned operands.
  - DONE: `out_valid`=1, and `out`/`zr`/`ng` are held stable.
    - `in_ready` = `out_ready`, giving pass-through for back-to-back beats.
    - Transfer with no new accept → IDLE.
    - Transfer with a simultaneous accept:
      - `mul`=0: stays in DONE with the new result.
      - `mul`=1: goes to MUL.
    - No transfer: the state is held and nothing is accepted.
- Boundaries:
  - `in_valid` is ignored whenever `in_ready`=0.
  - Operands are captured at accept. Input changes afterwards have no effect.
  - `x`, `y` and `ctrl` are don't-care when `in_valid`=0.

## Timing
- Reset values, held while `reset` is high and on the first cycle after it: state IDLE, `out_valid`=0, `out`=0, `zr`=1, `ng`=0, counter=0.
- `in_ready` is forced to 0 while `reset` is high.
- `reset` mid-multiply or mid-DONE discards the pending result with no transfer. `in_ready`=1 in the cycle after `reset` falls.
- Standard-op latency: accept at edge E0, `out_valid` high from E0 on.
- Standard-op throughput: 1 beat per cycle with `out_ready` held high.
- Multiply latency: accept at E0, MUL occupies edges E1..E`WIDTH`, `out_valid` high from E`WIDTH` on.
  - Throughput is 1 beat per `WIDTH`+1 cycles.
- All outputs are registered, except `in_ready`, which is combinational from state, `out_ready` and `reset`.
- No combinational path exists from `in_valid` to any output.

## Configuration
- `ALU_MUL_EN` defined:
  - MUL state, counter, accumulator and shift registers are compiled in.
  - `mul`=1 selects multiply.
- `ALU_MUL_EN` undefined:
  - No MUL state or multiply logic exists.
  - `mul` is ignored and every beat runs the `ctrl` function with standard latency.

## Test plan
- Add: `WIDTH`=16, x=5, y=3, `ctrl`=000010 → `out`=0x0008, `zr`=0, `ng`=0. `out_valid` high the cycle after accept.
- Subtract: x=3, y=5, `ctrl`=010011 (x−y) → `out`=0xFFFE, `ng`=1, `zr`=0.
- Constant zero: x=0x1234, y=0x5678, `ctrl`=101010 → `out`=0, `zr`=1, `ng`=0.
- Backpressure:
  - Phase 1: hold `out_ready`=0 for 3 cycles after a result. `out` must stay stable, `in_ready`=0 and a pending input must not be taken.
  - Phase 2: raise `out_ready` with 4 back-to-back beats (x&y, x|y via `ctrl`=010101, !x, −1). Expect 4 results on 4 consecutive cycles, in order.
- Multiply (macro on): x=0xFFFD, y=0x0007, `mul`=1 → `out`=0xFFEB, `ng`=1. `out_valid` first high exactly 16 edges after accept, and `in_ready`=0 throughout.
  - With the macro off, the same beat using `ctrl`=000010 gives 0x0004 with 1-cycle latency.
- Reset mid-multiply: assert `reset` on MUL iteration 5 → `out_valid`=0, `out`=0, `zr`=1.
  - `in_ready`=1 the cycle after `reset` falls.
  - A following add of 5+3 must return 8.
